cm_sketch_update: RTL and testbench

Count-min sketch counter stage sitting directly downstream of `header_hash`. It consumes the per-row hash indices and their valid strobe, and performs a pipelined read-modify-write on one counter RAM per row. It returns the count-min estimate for every update and, after reset or on request, sweeps all counters to zero. It runs at one update per cycle with no backpressure, because `header_hash` cannot be stalled.

---
 rtl/cm_sketch_update_pkg.sv | 20 ++
 rtl/cm_row_ram.sv | 27 ++
 rtl/cm_sketch_update.sv | 184 ++++++++++++++++++
 tb/tb_cm_sketch_update.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cm_sketch_update_pkg.sv
// Shared definitions for the count-min sketch counter stage: FSM encoding,
// drop counter width and the saturating increment used for counters and estimates.
package cm_sketch_update_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int DROP_W = 16;
  localparam int SAT_W  = 64;

  // Saturating +1 on a value that is w bits wide (w <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int w);
    logic [SAT_W-1:0] max_v;
    max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v >= max_v) ? max_v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/cm_row_ram.sv
// One sketch row: simple dual-port counter RAM, synchronous read, read-first on
// a same-address read/write collision. Contents are not reset.
module cm_row_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [CNT_WIDTH-1:0]  wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [CNT_WIDTH-1:0]  rdata
);

  logic [CNT_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [CNT_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cm_sketch_update.sv
// Count-min sketch counter stage: pipelined per-row read-modify-write with a
// zero sweep after reset or on request. CM_CONSERVATIVE_UPDATE_EN selects conservative update.
module cm_sketch_update
  import cm_sketch_update_pkg::*;
#(
  parameter int NUM_ROWS   = 10,
  parameter int HASH_WIDTH = 19,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_ROWS*HASH_WIDTH-1:0] hash_bus,
  input  logic                           hash_vld,
  input  logic                           clear_req,
  output logic [CNT_WIDTH-1:0]           est,
  output logic                           est_vld,
  output logic                           busy,
  output logic [DROP_W-1:0]              drop_cnt,
  output logic                           dbg_state
);

  // Handshake: hash_vld is a one-cycle push with no ready; est_vld is a
  // one-cycle strobe three cycles after the accepted push, with no backpressure.

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_addr_q, sweep_addr_d;
  logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic                  accept;

  logic                  s1_vld_q, s1_vld_d;
  logic                  s2_vld_q, s2_vld_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q [NUM_ROWS];
  logic [ADDR_WIDTH-1:0] s1_addr_d [NUM_ROWS];
  logic [ADDR_WIDTH-1:0] s2_addr_q [NUM_ROWS];
  logic [ADDR_WIDTH-1:0] s2_addr_d [NUM_ROWS];

  logic [NUM_ROWS-1:0]   fwd_vld_q, fwd_vld_d;
  logic [ADDR_WIDTH-1:0] fwd_addr_q [NUM_ROWS];
  logic [ADDR_WIDTH-1:0] fwd_addr_d [NUM_ROWS];
  logic [CNT_WIDTH-1:0]  fwd_data_q [NUM_ROWS];
  logic [CNT_WIDTH-1:0]  fwd_data_d [NUM_ROWS];

  logic [CNT_WIDTH-1:0]  est_q, est_d;
  logic                  est_vld_q, est_vld_d;

  logic [CNT_WIDTH-1:0]  cur_cnt [NUM_ROWS];
  logic [CNT_WIDTH-1:0]  new_cnt [NUM_ROWS];
  logic [CNT_WIDTH-1:0]  min_cnt;
  logic [NUM_ROWS-1:0]   row_upd;

  logic [NUM_ROWS-1:0]   ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr [NUM_ROWS];
  logic [CNT_WIDTH-1:0]  ram_wdata [NUM_ROWS];
  logic [CNT_WIDTH-1:0]  ram_rdata [NUM_ROWS];

  logic                  unused_hash_bits;
  assign unused_hash_bits = ^hash_bus;

  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    drop_cnt_d   = drop_cnt_q;
    accept       = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        sweep_addr_d = sweep_addr_q + ADDR_WIDTH'(1);
        if (sweep_addr_q == '1) begin
          state_d = ST_RUN;
        end
        if (hash_vld && (drop_cnt_q != '1)) begin
          drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
      end
      ST_RUN: begin
        accept = hash_vld;
        if (clear_req) begin
          state_d      = ST_CLEAR;
          sweep_addr_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    s1_vld_d = accept;
    s2_vld_d = s1_vld_q;
    for (int r = 0; r < NUM_ROWS; r++) begin
      s1_addr_d[r] = hash_bus[r*HASH_WIDTH +: ADDR_WIDTH];
      s2_addr_d[r] = s1_addr_q[r];
    end
  end

  // Forward from the item that was in S2 last cycle: its write landed on the
  // same edge as our read-first RAM read, so the RAM data is one update stale.
  always_comb begin
    min_cnt = '1;
    for (int r = 0; r < NUM_ROWS; r++) begin
      cur_cnt[r] = (fwd_vld_q[r] && (fwd_addr_q[r] == s2_addr_q[r])) ? fwd_data_q[r] : ram_rdata[r];
      if (cur_cnt[r] < min_cnt) begin
        min_cnt = cur_cnt[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      new_cnt[r] = CNT_WIDTH'(sat_inc(SAT_W'(cur_cnt[r]), CNT_WIDTH));
`ifdef CM_CONSERVATIVE_UPDATE_EN
      row_upd[r] = (cur_cnt[r] == min_cnt);
`else
      row_upd[r] = 1'b1;
`endif
      fwd_vld_d[r]  = s2_vld_q && row_upd[r];
      fwd_addr_d[r] = s2_addr_q[r];
      fwd_data_d[r] = new_cnt[r];
      // The sweep owns the write port; in-flight updates still compute but never write.
      if (state_q == ST_CLEAR) begin
        ram_we[r]    = 1'b1;
        ram_waddr[r] = sweep_addr_q;
        ram_wdata[r] = '0;
      end else begin
        ram_we[r]    = s2_vld_q && row_upd[r];
        ram_waddr[r] = s2_addr_q[r];
        ram_wdata[r] = new_cnt[r];
      end
    end
    est_vld_d = s2_vld_q;
    est_d     = s2_vld_q ? CNT_WIDTH'(sat_inc(SAT_W'(min_cnt), CNT_WIDTH)) : est_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_CLEAR;
      sweep_addr_q <= '0;
      drop_cnt_q   <= '0;
      s1_vld_q     <= 1'b0;
      s2_vld_q     <= 1'b0;
      fwd_vld_q    <= '0;
      est_q        <= '0;
      est_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      drop_cnt_q   <= drop_cnt_d;
      s1_vld_q     <= s1_vld_d;
      s2_vld_q     <= s2_vld_d;
      fwd_vld_q    <= fwd_vld_d;
      est_q        <= est_d;
      est_vld_q    <= est_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      s1_addr_q[r]  <= s1_addr_d[r];
      s2_addr_q[r]  <= s2_addr_d[r];
      fwd_addr_q[r] <= fwd_addr_d[r];
      fwd_data_q[r] <= fwd_data_d[r];
    end
  end

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    cm_row_ram #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ram (
      .clk  (clk),
      .we   (ram_we[g]),
      .waddr(ram_waddr[g]),
      .wdata(ram_wdata[g]),
      .raddr(s1_addr_q[g]),
      .rdata(ram_rdata[g])
    );
  end

  assign est       = est_q;
  assign est_vld   = est_vld_q;
  assign busy      = (state_q == ST_CLEAR);
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cm_sketch_update.sv
// Directed bench for cm_sketch_update: scoreboard queues filled by the drivers,
// drained by a negedge monitor on est_vld.
module tb_cm_sketch_update;

  localparam int NR    = 10;
  localparam int HW    = 19;
  localparam int BUS_W = NR * HW;

  logic             clk;
  logic             reset;
  logic [BUS_W-1:0] hash_bus;
  logic             hash_vld;
  logic             hash_vld4;
  logic             clear_req;
  logic             clear_req4;
  logic [31:0]      est;
  logic             est_vld;
  logic             busy;
  logic [15:0]      drop_cnt;
  logic             dbg_state;
  logic [3:0]       est4;
  logic             est_vld4;
  logic             busy4;
  logic [15:0]      drop_cnt4;
  logic             dbg_state4;

  logic [63:0] exp_q[$];
  logic [63:0] exp4_q[$];
  int          cyc;
  int          n_vec;
  int          n_fail;

  cm_sketch_update dut (
    .clk(clk), .reset(reset), .hash_bus(hash_bus), .hash_vld(hash_vld),
    .clear_req(clear_req), .est(est), .est_vld(est_vld), .busy(busy),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  cm_sketch_update #(.CNT_WIDTH(4), .ADDR_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .hash_bus(hash_bus), .hash_vld(hash_vld4),
    .clear_req(clear_req4), .est(est4), .est_vld(est_vld4), .busy(busy4),
    .drop_cnt(drop_cnt4), .dbg_state(dbg_state4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int row_addr(input int s, input int r);
    return (s * 97 + r * 131) % 1024;
  endfunction

  function automatic logic [BUS_W-1:0] make_key(input int s);
    logic [BUS_W-1:0] k;
    k = '0;
    for (int r = 0; r < NR; r++) begin
      k[r*HW +: HW] = HW'(row_addr(s, r) | (((s + r) % 256) << 11));
    end
    return k;
  endfunction

  // Key with seed s_own in every row except row 0, which copies seed s_col.
  function automatic logic [BUS_W-1:0] collide_key(input int s_own, input int s_col);
    logic [BUS_W-1:0] k;
    logic [BUS_W-1:0] c;
    k = make_key(s_own);
    c = make_key(s_col);
    k[HW-1:0] = c[HW-1:0];
    return k;
  endfunction

  // driver tasks
  task automatic drive(input logic [BUS_W-1:0] k, input logic clr, input logic push, input logic [31:0] e);
    hash_bus  = k;
    hash_vld  = 1'b1;
    clear_req = clr;
    if (push) exp_q.push_back({32'(cyc + 3), e});
    @(negedge clk);
    hash_vld  = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic drive4(input logic [BUS_W-1:0] k, input logic [3:0] e);
    hash_bus  = k;
    hash_vld4 = 1'b1;
    exp4_q.push_back({32'(cyc + 3), 28'd0, e});
    @(negedge clk);
    hash_vld4 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sweep(input string name, input int exp_len);
    int cnt;
    cnt = 0;
    while (busy && cnt < 4000) begin
      cnt++;
      @(negedge clk);
    end
    check(name, 64'(cnt), 64'(exp_len));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (reset && est_vld) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL est_vld_unexpected: got est_vld=1 est=%0d expected no output (cycle %0d)", est, cyc);
      end else begin
        e = exp_q.pop_front();
        check("est", 64'(est), 64'(e[31:0]));
        check("est_latency", 64'(cyc), 64'(e[63:32]));
      end
    end
    if (reset && est_vld4) begin
      if (exp4_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL est4_vld_unexpected: got est_vld=1 est=%0d expected no output (cycle %0d)", est4, cyc);
      end else begin
        e = exp4_q.pop_front();
        check("est4_sat", 64'(est4), 64'(e[3:0]));
        check("est4_latency", 64'(cyc), 64'(e[63:32]));
      end
    end
  end

  initial begin
    logic [BUS_W-1:0] k;
    int cnt;
    n_vec      = 0;
    n_fail     = 0;
    reset      = 1'b0;
    hash_bus   = '0;
    hash_vld   = 1'b0;
    hash_vld4  = 1'b0;
    clear_req  = 1'b0;
    clear_req4 = 1'b0;
    idle(3);

    check("rst_est", 64'(est), 64'd0);
    check("rst_est_vld", 64'(est_vld), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_state_clear", 64'(dbg_state), 64'd0);

    reset = 1'b1;
    wait_sweep("busy_after_reset", 1024);
    check("state_run", 64'(dbg_state), 64'd1);

    // single update
    drive(make_key(1), 1'b0, 1'b1, 32'd1);
    idle(4);

    // same key back to back: forwarding path
    k = make_key(2);
    for (int i = 1; i <= 3; i++) drive(k, 1'b0, 1'b1, 32'(i));
    idle(4);

    // D, E, D with E colliding with D in row 0 only
    drive(make_key(3), 1'b0, 1'b1, 32'd1);
    drive(collide_key(4, 3), 1'b0, 1'b1, 32'd1);
    drive(make_key(3), 1'b0, 1'b1, 32'd2);
    idle(5);
`ifdef CM_CONSERVATIVE_UPDATE_EN
    check("row0_collide_cnt", 64'(dut.g_row[0].u_ram.mem_q[10'(row_addr(3, 0))]), 64'd2);
`else
    check("row0_collide_cnt", 64'(dut.g_row[0].u_ram.mem_q[10'(row_addr(3, 0))]), 64'd3);
`endif

    // alternating keys: every repeat is two behind, read from RAM
    drive(make_key(5), 1'b0, 1'b1, 32'd1);
    drive(make_key(6), 1'b0, 1'b1, 32'd1);
    drive(make_key(5), 1'b0, 1'b1, 32'd2);
    drive(make_key(6), 1'b0, 1'b1, 32'd2);
    drive(make_key(5), 1'b0, 1'b1, 32'd3);
    idle(4);

    // clear while 5 updates are in flight, 4 drops during the sweep
    k = make_key(7);
    for (int i = 1; i <= 5; i++) drive(k, (i == 5), 1'b1, 32'(i));
    check("busy_after_clear_req", 64'(busy), 64'd1);
    cnt = 0;
    hash_bus = make_key(9);
    while (busy && cnt < 4000) begin
      hash_vld  = (cnt < 3) || (cnt == 1023);
      clear_req = (cnt == 100);
      cnt++;
      @(negedge clk);
    end
    hash_vld  = 1'b0;
    clear_req = 1'b0;
    check("busy_len_clear", 64'(cnt), 64'd1024);
    drive(make_key(7), 1'b0, 1'b1, 32'd1);
    drive(make_key(3), 1'b0, 1'b1, 32'd1);
    idle(5);
    check("drop_cnt", 64'(drop_cnt), 64'd4);

    // saturation on the 4-bit instance
    k = make_key(11);
    for (int i = 1; i <= 17; i++) drive4(k, (i > 15) ? 4'hF : 4'(i));
    idle(5);
    check("row0_sat_cnt", 64'(dut4.g_row[0].u_ram.mem_q[4'(row_addr(11, 0))]), 64'd15);

    // reset mid-flight: no est_vld for in-flight items
    k = make_key(12);
    drive(k, 1'b0, 1'b0, 32'd0);
    drive(k, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_est_vld", 64'(est_vld), 64'd0);
    end
    check("rst_mid_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    wait_sweep("busy_after_rst_mid", 1024);
    drive(make_key(13), 1'b0, 1'b1, 32'd1);
    idle(5);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("sb4_empty", 64'(exp4_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
